// File: rtl/simd_addsub_acc.sv
// Two-stage registered N-lane SIMD add/sub/accumulate/load unit with per-lane
// accumulators, saturating or wrapping arithmetic and valid/ready flow control.
module simd_addsub_acc #(
  parameter int N = 4,
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   op,
  input  logic         sat,
  input  logic         sgn,
  input  logic [W-1:0] a [N-1:0],
  input  logic [W-1:0] b [N-1:0],
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out [N-1:0],
  output logic [N-1:0] ovf
);

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_ACC  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  logic         s1_valid_r;
  logic [1:0]   s1_op_r;
  logic         s1_sat_r;
  logic         s1_sgn_r;
  logic [W-1:0] s1_a_r [N-1:0];
  logic [W-1:0] s1_b_r [N-1:0];
  logic [W-1:0] acc_r [N-1:0];
  logic [W:0]   lane_s [N-1:0];
  logic [W-1:0] res_s [N-1:0];
  logic [N-1:0] res_ovf_s;
  logic         s2_free_s;
  logic         advance_s;
  logic         accept_s;

  // One lane in W+1 bits; returns {overflow, clamped-or-wrapped result}.
  function automatic logic [W:0] lane_calc(
    input logic [W-1:0] x,
    input logic [W-1:0] y,
    input logic         sub,
    input logic         do_sat,
    input logic         is_sgn
  );
    logic [W:0]   xe;
    logic [W:0]   ye;
    logic [W:0]   r;
    logic         o;
    logic [W-1:0] v;
    xe = {is_sgn & x[W-1], x};
    ye = {is_sgn & y[W-1], y};
    if (sub) begin
      r = xe - ye;
    end else begin
      r = xe + ye;
    end
    // Signed: the extra bit disagrees with the W-bit sign; unsigned: carry/borrow out.
    if (is_sgn) begin
      o = r[W] ^ r[W-1];
    end else begin
      o = r[W];
    end
    if (o && do_sat) begin
      if (is_sgn) begin
        v = r[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      end else if (sub) begin
        v = {W{1'b0}};
      end else begin
        v = {W{1'b1}};
      end
    end else begin
      v = r[W-1:0];
    end
    return {o, v};
  endfunction

  assign s2_free_s = !out_valid || out_ready;
  assign advance_s = s1_valid_r && s2_free_s;
  assign in_ready  = !s1_valid_r || s2_free_s;
  assign accept_s  = in_valid && in_ready;

  // Stage-1 operand and mode capture on the input handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_op_r    <= 2'b00;
      s1_sat_r   <= 1'b0;
      s1_sgn_r   <= 1'b0;
      for (int i = 0; i < N; i++) begin
        s1_a_r[i] <= {W{1'b0}};
        s1_b_r[i] <= {W{1'b0}};
      end
    end else if (accept_s) begin
      s1_valid_r <= 1'b1;
      s1_op_r    <= op;
      s1_sat_r   <= sat;
      s1_sgn_r   <= sgn;
      for (int i = 0; i < N; i++) begin
        s1_a_r[i] <= a[i];
        s1_b_r[i] <= b[i];
      end
    end else if (advance_s) begin
      s1_valid_r <= 1'b0;
    end
  end

  // Per-lane result; ACC reads the accumulator already updated by the previous beat.
  always_comb begin
    res_ovf_s = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      lane_s[i] = {(W+1){1'b0}};
      case (s1_op_r)
        OP_ADD:  lane_s[i] = lane_calc(s1_a_r[i], s1_b_r[i], 1'b0, s1_sat_r, s1_sgn_r);
        OP_SUB:  lane_s[i] = lane_calc(s1_a_r[i], s1_b_r[i], 1'b1, s1_sat_r, s1_sgn_r);
        OP_ACC:  lane_s[i] = lane_calc(acc_r[i], s1_a_r[i], 1'b0, s1_sat_r, s1_sgn_r);
        OP_LOAD: lane_s[i] = {1'b0, s1_a_r[i]};
        default: lane_s[i] = {1'b0, s1_a_r[i]};
      endcase
      res_s[i]     = lane_s[i][W-1:0];
      res_ovf_s[i] = lane_s[i][W];
    end
  end

  // Stage-2 output registers and accumulators, held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      ovf       <= {N{1'b0}};
      for (int i = 0; i < N; i++) begin
        out[i]   <= {W{1'b0}};
        acc_r[i] <= {W{1'b0}};
      end
    end else if (advance_s) begin
      out_valid <= 1'b1;
      ovf       <= res_ovf_s;
      for (int i = 0; i < N; i++) begin
        out[i] <= res_s[i];
        if ((s1_op_r == OP_ACC) || (s1_op_r == OP_LOAD)) begin
          acc_r[i] <= res_s[i];
        end
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_simd_addsub_acc.sv
// Self-checking bench: directed vector table, accumulate/backpressure/reset
// sequences, then a random soak on a 4x10 and a 2x16 instance.
module tb_simd_addsub_acc;

  typedef struct packed {
    logic [3:0][9:0]  v1;
    logic [3:0]       o1;
    logic [1:0][15:0] v2;
    logic [1:0]       o2;
  } exp_t;

  typedef struct {
    logic [1:0]      op;
    logic            sat;
    logic            sgn;
    logic [3:0][9:0] a;
    logic [3:0][9:0] b;
    logic [3:0][9:0] ev;
    logic [3:0]      eo;
  } vec_t;

  logic clk, rst, in_valid, out_ready, sat, sgn;
  logic [1:0] op;
  logic in_ready, out_valid, in_ready2, out_valid2;
  logic [9:0]  a1 [3:0];
  logic [9:0]  b1 [3:0];
  logic [9:0]  out1 [3:0];
  logic [3:0]  ovf1;
  logic [15:0] a2 [1:0];
  logic [15:0] b2 [1:0];
  logic [15:0] out2 [1:0];
  logic [1:0]  ovf2;
  logic [3:0][9:0]  out1_p;
  logic [1:0][15:0] out2_p;

  int   nvec = 0;
  int   nfail = 0;
  int   cyc = 0;
  int   stall_from = -1;
  int   stall_to = -2;
  logic rand_ready = 1'b0;
  logic last_ov = 1'b0;
  logic saw_block = 1'b0;
  exp_t q[$];
  vec_t tbl[10];

  simd_addsub_acc #(.N(4), .W(10)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .sat(sat), .sgn(sgn), .a(a1), .b(b1), .out_valid(out_valid),
    .out_ready(out_ready), .out(out1), .ovf(ovf1));

  simd_addsub_acc #(.N(2), .W(16)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .op(op),
    .sat(sat), .sgn(sgn), .a(a2), .b(b2), .out_valid(out_valid2),
    .out_ready(out_ready), .out(out2), .ovf(ovf2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 4; i++) out1_p[i] = out1[i];
    for (int i = 0; i < 2; i++) out2_p[i] = out2[i];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Signed or unsigned value of the low w bits.
  function automatic longint sval(input logic [15:0] x, input int w, input logic s);
    longint v;
    v = longint'(x) & ((longint'(1) << w) - 1);
    if (s && v >= (longint'(1) << (w - 1))) v = v - (longint'(1) << w);
    return v;
  endfunction

  // Reference lane: exact integer result, range check, clamp or reduce mod 2^w.
  function automatic logic [16:0] ref_lane(input int w, input logic [15:0] x, input logic [15:0] y,
                                           input logic [15:0] ac, input logic [1:0] o,
                                           input logic st, input logic s);
    longint m, ex, lo, hi, r;
    logic of;
    m = longint'(1) << w;
    case (o)
      2'b00:   ex = sval(x, w, s) + sval(y, w, s);
      2'b01:   ex = sval(x, w, s) - sval(y, w, s);
      2'b10:   ex = sval(ac, w, s) + sval(x, w, s);
      default: return {1'b0, 16'(longint'(x) & (m - 1))};
    endcase
    lo = s ? -(m / 2) : 0;
    hi = s ? (m / 2) - 1 : m - 1;
    of = (ex < lo) || (ex > hi);
    r = ex;
    if (of && st) r = (ex > hi) ? hi : lo;
    return {of, 16'(r & (m - 1))};
  endfunction

  function automatic logic [15:0] rnd(input int w);
    logic [15:0] m;
    m = 16'((32'd1 << w) - 32'd1);
    case ($urandom_range(0, 4))
      0:       return 16'd0;
      1:       return m;
      2:       return 16'(32'd1 << (w - 1));
      3:       return 16'((32'd1 << (w - 1)) - 32'd1);
      default: return 16'($urandom) & m;
    endcase
  endfunction

  function automatic logic [3:0][9:0] rep10(input logic [9:0] x);
    return {x, x, x, x};
  endfunction

  function automatic exp_t mk(input logic [3:0][9:0] v, input logic [3:0] o);
    exp_t e;
    e.v1 = v; e.o1 = o; e.v2 = '0; e.o2 = 2'b00;
    return e;
  endfunction

  // One clock: called at a negedge with inputs set; checks, updates scoreboard.
  task automatic cycle(input exp_t e, output logic hs);
    if (cyc >= stall_from && cyc <= stall_to) out_ready = 1'b0;
    else if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    else out_ready = 1'b1;
    #1;
    hs = 1'b0;
    last_ov = out_valid;
    if (rst) begin
      q.delete();
    end else begin
      if (in_ready === 1'b0) saw_block = 1'b1;
      chk("in_ready", in_ready, (q.size() < 2) || out_ready);
      chk("in_ready_w16", in_ready2, (q.size() < 2) || out_ready);
      if (q.size() == 0) begin
        chk("out_valid_idle", out_valid, 0);
        chk("out_valid_idle_w16", out_valid2, 0);
      end else begin
        if (q.size() == 2) begin
          chk("out_valid_full", out_valid, 1);
          chk("out_valid_full_w16", out_valid2, 1);
        end
        if (out_valid) begin
          chk("out", out1_p, q[0].v1);
          chk("ovf", ovf1, q[0].o1);
          chk("out_w16", out2_p, q[0].v2);
          chk("ovf_w16", ovf2, q[0].o2);
        end
      end
      if (out_valid && out_ready) void'(q.pop_front());
      hs = in_valid && in_ready;
      if (hs) q.push_back(e);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic send(input logic [1:0] o, input logic st, input logic s,
                      input logic [3:0][9:0] av, input logic [3:0][9:0] bv, input exp_t e);
    logic hs;
    int n;
    in_valid = 1'b1; op = o; sat = st; sgn = s;
    for (int i = 0; i < 4; i++) begin a1[i] = av[i]; b1[i] = bv[i]; end
    for (int i = 0; i < 2; i++) begin a2[i] = 16'd0; b2[i] = 16'd0; end
    hs = 1'b0; n = 0;
    while (!hs && n < 20) begin cycle(e, hs); n++; end
    in_valid = 1'b0;
    chk("send_accepted", hs, 1);
  endtask

  task automatic drain();
    logic hs;
    int n;
    in_valid = 1'b0; n = 0;
    while (q.size() > 0 && n < 40) begin cycle('0, hs); n++; end
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    logic hs;
    logic [15:0] macc1 [4];
    logic [15:0] macc2 [2];
    logic [15:0] nacc1 [4];
    logic [15:0] nacc2 [2];
    logic [16:0] r;
    exp_t e;
    int beats;

    tbl[0] = '{2'b00, 1'b0, 1'b0, {10'd1023, 10'd3, 10'd2, 10'd1}, {10'd1, 10'd3, 10'd2, 10'd1},
               {10'd0, 10'd6, 10'd4, 10'd2}, 4'b1000};
    tbl[1] = '{2'b01, 1'b1, 1'b0, {10'd7, 10'd100, 10'd0, 10'd5}, {10'd8, 10'd100, 10'd1, 10'd3},
               {10'd0, 10'd0, 10'd0, 10'd2}, 4'b1010};
    tbl[2] = '{2'b01, 1'b1, 1'b1, {10'h3FB, 10'h1FF, 10'h064, 10'h200}, {10'h3FB, 10'h3FF, 10'h3E4, 10'h001},
               {10'h000, 10'h1FF, 10'h080, 10'h200}, 4'b0101};
    tbl[3] = '{2'b01, 1'b0, 1'b1, {10'h3FB, 10'h1FF, 10'h064, 10'h200}, {10'h3FB, 10'h3FF, 10'h3E4, 10'h001},
               {10'h000, 10'h200, 10'h080, 10'h1FF}, 4'b0101};
    tbl[4] = '{2'b00, 1'b1, 1'b0, {10'd1000, 10'd0, 10'd512, 10'd1023}, {10'd100, 10'd0, 10'd511, 10'd1},
               {10'd1023, 10'd0, 10'd1023, 10'd1023}, 4'b1001};
    tbl[5] = '{2'b00, 1'b1, 1'b1, {10'h3FF, 10'h100, 10'h200, 10'h1FF}, {10'h3FF, 10'h0FF, 10'h3FF, 10'h001},
               {10'h3FE, 10'h1FF, 10'h200, 10'h1FF}, 4'b0011};
    tbl[6] = '{2'b00, 1'b0, 1'b1, {10'h3FF, 10'h100, 10'h200, 10'h1FF}, {10'h3FF, 10'h0FF, 10'h3FF, 10'h001},
               {10'h3FE, 10'h1FF, 10'h1FF, 10'h200}, 4'b0011};
    tbl[7] = '{2'b01, 1'b0, 1'b0, {10'd0, 10'd10, 10'd1023, 10'd3}, {10'd1, 10'd20, 10'd0, 10'd3},
               {10'd1023, 10'd1014, 10'd1023, 10'd0}, 4'b1100};
    tbl[8] = '{2'b11, 1'b0, 1'b1, {10'h000, 10'h200, 10'h3FF, 10'h007}, {10'd1, 10'd2, 10'd3, 10'd4},
               {10'h000, 10'h200, 10'h3FF, 10'h007}, 4'b0000};
    tbl[9] = '{2'b10, 1'b0, 1'b0, {10'h005, 10'h200, 10'h001, 10'h001}, {10'd9, 10'd9, 10'd9, 10'd9},
               {10'h005, 10'h000, 10'h000, 10'h008}, 4'b0110};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = 2'b00; sat = 1'b0; sgn = 1'b0;
    for (int i = 0; i < 4; i++) begin a1[i] = '0; b1[i] = '0; end
    for (int i = 0; i < 2; i++) begin a2[i] = '0; b2[i] = '0; end
    @(negedge clk);

    // Reset state
    cycle('0, hs); cycle('0, hs);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out", out1_p, 0);
    chk("rst_ovf", ovf1, 0);
    chk("rst_in_ready", in_ready, 1);

    // Directed table: one beat each, latency 2, out_valid for exactly one cycle
    for (int k = 0; k < 10; k++) begin
      send(tbl[k].op, tbl[k].sat, tbl[k].sgn, tbl[k].a, tbl[k].b, mk(tbl[k].ev, tbl[k].eo));
      cycle('0, hs); chk("lat_cycle1", last_ov, 0);
      cycle('0, hs); chk("lat_cycle2", last_ov, 1);
      cycle('0, hs); chk("lat_cycle3", last_ov, 0);
      chk("vec_consumed", q.size(), 0);
    end

    // Back-to-back accumulate, signed saturating; ADD in between leaves acc alone
    send(2'b11, 1'b1, 1'b1, rep10(10'd10), rep10(10'd0), mk(rep10(10'd10), 4'b0000));
    send(2'b10, 1'b1, 1'b1, rep10(10'd200), rep10(10'd0), mk(rep10(10'd210), 4'b0000));
    send(2'b10, 1'b1, 1'b1, rep10(10'd200), rep10(10'd0), mk(rep10(10'd410), 4'b0000));
    send(2'b10, 1'b1, 1'b1, rep10(10'd200), rep10(10'd0), mk(rep10(10'd511), 4'b1111));
    send(2'b00, 1'b1, 1'b1, rep10(10'd1), rep10(10'd1), mk(rep10(10'd2), 4'b0000));
    send(2'b10, 1'b1, 1'b1, rep10(10'h39C), rep10(10'd0), mk(rep10(10'h19B), 4'b0000));
    drain();

    // Backpressure: consumer stalls for relative cycles 3..6
    saw_block = 1'b0;
    stall_from = cyc + 3; stall_to = cyc + 6;
    for (int k = 0; k < 6; k++) begin
      send(2'b00, 1'b0, 1'b0, {10'(k + 30), 10'(k + 20), 10'(k + 10), 10'(k)}, rep10(10'(k)),
           mk({10'(2 * k + 30), 10'(2 * k + 20), 10'(2 * k + 10), 10'(2 * k)}, 4'b0000));
    end
    drain();
    chk("in_ready_dropped", saw_block, 1);

    // Reset with both stages occupied and a nonzero accumulator
    stall_from = cyc + 2; stall_to = cyc + 20;
    send(2'b11, 1'b0, 1'b0, rep10(10'd5), rep10(10'd0), mk(rep10(10'd5), 4'b0000));
    send(2'b10, 1'b0, 1'b0, rep10(10'd3), rep10(10'd0), mk(rep10(10'd8), 4'b0000));
    cycle('0, hs);
    rst = 1'b1;
    cycle('0, hs);
    rst = 1'b0; stall_from = -1; stall_to = -2;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out", out1_p, 0);
    chk("midrst_ovf", ovf1, 0);
    send(2'b10, 1'b0, 1'b0, rep10(10'd1), rep10(10'd0), mk(rep10(10'd1), 4'b0000));
    drain();

    // Random soak on both widths against the reference model
    rst = 1'b1; cycle('0, hs); rst = 1'b0;
    for (int i = 0; i < 4; i++) macc1[i] = 16'd0;
    for (int i = 0; i < 2; i++) macc2[i] = 16'd0;
    rand_ready = 1'b1;
    beats = 0;
    for (int t = 0; t < 40000 && beats < 10000; t++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      op = 2'($urandom); sat = 1'($urandom); sgn = 1'($urandom);
      rst = ($urandom_range(0, 1999) == 0);
      for (int i = 0; i < 4; i++) begin
        a1[i] = 10'(rnd(10)); b1[i] = 10'(rnd(10));
        r = ref_lane(10, 16'(a1[i]), 16'(b1[i]), macc1[i], op, sat, sgn);
        e.v1[i] = r[9:0]; e.o1[i] = r[16];
        nacc1[i] = (op[1]) ? r[15:0] : macc1[i];
      end
      for (int i = 0; i < 2; i++) begin
        a2[i] = rnd(16); b2[i] = rnd(16);
        r = ref_lane(16, a2[i], b2[i], macc2[i], op, sat, sgn);
        e.v2[i] = r[15:0]; e.o2[i] = r[16];
        nacc2[i] = (op[1]) ? r[15:0] : macc2[i];
      end
      cycle(e, hs);
      if (rst) begin
        for (int i = 0; i < 4; i++) macc1[i] = 16'd0;
        for (int i = 0; i < 2; i++) macc2[i] = 16'd0;
      end else if (hs) begin
        for (int i = 0; i < 4; i++) macc1[i] = nacc1[i];
        for (int i = 0; i < 2; i++) macc2[i] = nacc2[i];
        beats++;
      end
    end
    rst = 1'b0;
    rand_ready = 1'b0;
    drain();
    chk("soak_beats", beats >= 10000, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
